// File: rtl/dmem_req_sequencer.sv
// dmem_req_sequencer: two-port round-robin data-memory controller.
// Serialises byte/half/word accesses onto a byte-wide sync RAM.
module dmem_req_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [1:0]        r0_size,
  input  logic [31:0]       r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_ack,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [1:0]        r1_size,
  input  logic [31:0]       r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_ack,
  output logic [31:0]       r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    RDLAST,
    ACK
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              lgnt_q, lgnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rd0_q, rd0_d;
  logic [31:0]       rd1_q, rd1_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              men_q, men_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]        mwd_q, mwd_d;
  logic              busy_q, busy_d;

  logic              win1;
  logic [1:0]        sel_size;
  logic [1:0]        prev;
  logic [31:0]       fin;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^{r0_addr[31:ADDR_W],
                            r1_addr[31:ADDR_W]};

  // Port 1 wins when alone, or on a tie when port 0 went last.
  assign win1 = r1_req & (~r0_req | ~lgnt_q);

  // Next-state: grant/latch, beat walk, read assembly, ack.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    lgnt_d   = lgnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    asm_d    = asm_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    sel_size = 2'b00;
    prev     = beat_q - 2'd1;
    fin      = asm_q;
    unique case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          gnt_d    = win1;
          lgnt_d   = win1;
          we_d     = win1 ? r1_we : r0_we;
          sel_size = win1 ? r1_size : r0_size;
          addr_d   = win1 ? r1_addr[ADDR_W-1:0]
                          : r0_addr[ADDR_W-1:0];
          wdata_d  = win1 ? r1_wdata : r0_wdata;
          last_d   = sel_size[1] ? 2'd3
                                 : {1'b0, sel_size[0]};
          beat_d   = 2'd0;
          asm_d    = 32'h0;
          state_d  = BEAT;
        end
      end
      BEAT: begin
        if (beat_q != 2'd0) begin
          asm_d[{prev, 3'b000} +: 8] = mem_rdata;
        end
        if (beat_q == last_q) begin
          state_d = we_q ? ACK : RDLAST;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      RDLAST: begin
        fin[{last_q, 3'b000} +: 8] = mem_rdata;
        asm_d = fin;
        if (gnt_q) begin
          rd1_d = fin;
        end else begin
          rd0_d = fin;
        end
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output images derived from the next state so outputs are flops.
  always_comb begin
    men_d   = (state_d == BEAT);
    mwe_d   = men_d & we_d;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    if (men_d) begin
      maddr_d = addr_d + ADDR_W'(beat_d);
      mwd_d   = wdata_d[{beat_d, 3'b000} +: 8];
    end
    ack0_d = (state_d == ACK) & ~gnt_d;
    ack1_d = (state_d == ACK) & gnt_d;
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      last_q  <= 2'd0;
      gnt_q   <= 1'b0;
      lgnt_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      asm_q   <= 32'h0;
      rd0_q   <= 32'h0;
      rd1_q   <= 32'h0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      men_q   <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= 8'h0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      lgnt_q  <= lgnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      men_q   <= men_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
      busy_q  <= busy_d;
    end
  end

  assign r0_ack    = ack0_q;
  assign r1_ack    = ack1_q;
  assign r0_rdata  = rd0_q;
  assign r1_rdata  = rd1_q;
  assign mem_en    = men_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_req_sequencer.sv
// tb_dmem_req_sequencer: directed + random bench with a
// byte-array reference model and a behavioural sync RAM.
module tb_dmem_req_sequencer;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [1:0]    r0_size, r1_size;
  logic [31:0]   r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic          r0_ack, r1_ack;
  logic [31:0]   r0_rdata, r1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram [0:65535] = '{default: 8'h00};
  logic [7:0]  ref_mem [0:65535] = '{default: 8'h00};
  logic [31:0] exp_rd [0:1];
  int          lg;

  logic [AW-1:0] bq_addr [$];
  logic [7:0]    bq_data [$];
  logic          bq_we [$];

  always #5 clk = ~clk;

  dmem_req_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Byte-wide synchronous RAM, read data valid the next cycle.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  // Log every RAM beat seen on the bus.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      bq_addr.push_back(mem_addr);
      bq_data.push_back(mem_wdata);
      bq_we.push_back(mem_we);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic rq, input logic we,
                          input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      r0_req = rq; r0_we = we; r0_size = sz;
      r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = rq; r1_we = we; r1_size = sz;
      r1_addr = a; r1_wdata = d;
    end
  endtask

  function automatic int nbeats(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a,
                                           input logic [1:0] sz);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < nbeats(sz); k++)
      v |= 32'(ref_mem[16'(a + k)]) << (8 * k);
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d);
    for (int k = 0; k < nbeats(sz); k++)
      ref_mem[16'(a + k)] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [15:0] lo;
    if ($urandom_range(0, 3) == 0)
      lo = 16'hFFF8 + 16'($urandom_range(0, 7));
    else
      lo = 16'h0100 + 16'($urandom_range(0, 31));
    return {16'($urandom), lo};
  endfunction

  // One transaction on port p, started from an IDLE cycle at a negedge.
  task automatic xfer(input int p, input logic we, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdv);
    int n, lat;
    bit got;
    n = nbeats(sz);
    bq_addr.delete(); bq_data.delete(); bq_we.delete();
    set_port(p, 1'b1, we, sz, a, d);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) set_port(p, 1'b1, ~we, ~sz, ~a, ~d);
      @(negedge clk);
      if (lat == 1) chk("busy_rise", busy, 1);
      chk("other_ack", (p == 0) ? r1_ack : r0_ack, 0);
      got = (p == 0) ? r0_ack : r1_ack;
    end
    chk("ack_seen", got, 1);
    chk("latency", lat, we ? n + 1 : n + 2);
    chk("beat_count", bq_addr.size(), n);
    for (int k = 0; k < n && k < bq_addr.size(); k++) begin
      chk("beat_addr", bq_addr[k], 16'(a + k));
      chk("beat_we", bq_we[k], we);
      if (we) chk("beat_data", bq_data[k], d[8*k +: 8]);
    end
    if (we) ref_write(a, sz, d);
    else exp_rd[p] = ref_read(a, sz);
    rdv = (p == 0) ? r0_rdata : r1_rdata;
    chk("rdata_own", rdv, exp_rd[p]);
    chk("rdata_other", (p == 0) ? r1_rdata : r0_rdata, exp_rd[1-p]);
    lg = p;
    set_port(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    chk("ack_fall", (p == 0) ? r0_ack : r1_ack, 0);
  endtask

  // Both ports request together; served order follows round-robin.
  task automatic pair(input logic we0, input logic [1:0] s0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic we1, input logic [1:0] s1,
                      input logic [31:0] a1, input logic [31:0] d1);
    int first, cnt, cyc;
    int order [0:1];
    order = '{-1, -1};
    first = (lg == 1) ? 0 : 1;
    cnt = 0;
    cyc = 0;
    set_port(0, 1'b1, we0, s0, a0, d0);
    set_port(1, 1'b1, we1, s1, a1, d1);
    while (cnt < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (r0_ack === 1'b1) begin
        if (cnt < 2) order[cnt] = 0;
        cnt++;
        if (we0) ref_write(a0, s0, d0);
        else exp_rd[0] = ref_read(a0, s0);
        chk("pair_rd0", r0_rdata, exp_rd[0]);
        set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        lg = 0;
      end
      if (r1_ack === 1'b1) begin
        if (cnt < 2) order[cnt] = 1;
        cnt++;
        if (we1) ref_write(a1, s1, d1);
        else exp_rd[1] = ref_read(a1, s1);
        chk("pair_rd1", r1_rdata, exp_rd[1]);
        set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        lg = 1;
      end
    end
    chk("pair_done", cnt, 2);
    chk("pair_first", order[0], first);
    chk("pair_second", order[1], 1 - first);
    set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("pair_idle", busy, 0);
  endtask

  initial begin
    logic [31:0] rv, a0, a1, d0, d1;
    logic [1:0]  s0, s1;
    logic        w0, w1;
    int          cyc;

    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    exp_rd = '{32'h0, 32'h0};
    lg = 1;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ack0", r0_ack, 0);
    chk("rst_ack1", r1_ack, 0);
    chk("rst_rdata0", r0_rdata, 0);
    chk("rst_rdata1", r1_rdata, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Tie straight out of reset, then repeated ties.
    pair(1'b1, 2'b00, 32'h20, 32'h5A, 1'b1, 2'b00, 32'h21, 32'hA5);
    pair(1'b1, 2'b00, 32'h22, 32'h11, 1'b1, 2'b00, 32'h23, 32'h22);
    pair(1'b0, 2'b01, 32'h20, 32'h0, 1'b0, 2'b01, 32'h22, 32'h0);

    xfer(0, 1'b1, 2'b10, 32'h10, 32'hA1B2C3D4, rv);
    xfer(0, 1'b0, 2'b10, 32'h10, 32'h0, rv);
    chk("word_rd", rv, 32'hA1B2C3D4);
    xfer(0, 1'b0, 2'b01, 32'h11, 32'h0, rv);
    chk("half_rd", rv, 32'h0000B2C3);
    xfer(0, 1'b0, 2'b00, 32'h13, 32'h0, rv);
    chk("byte_rd", rv, 32'h000000A1);

    xfer(1, 1'b1, 2'b10, 32'h0000FFFE, 32'h11223344, rv);
    xfer(0, 1'b0, 2'b10, 32'h0000FFFE, 32'h0, rv);
    chk("wrap_rd", rv, 32'h11223344);
    xfer(1, 1'b1, 2'b11, 32'h0000FFFC, 32'hCAFEF00D, rv);
    xfer(1, 1'b0, 2'b11, 32'h0000FFFC, 32'h0, rv);
    chk("size3_rd", rv, 32'hCAFEF00D);

    xfer(0, 1'b1, 2'b10, 32'h40, 32'h12345678, rv);
    xfer(0, 1'b0, 2'b10, 32'h40, 32'h0, rv);
    chk("r0_pre", rv, 32'h12345678);
    xfer(1, 1'b0, 2'b10, 32'h10, 32'h0, rv);
    chk("r0_hold", r0_rdata, 32'h12345678);

    // Reset while beat 2 of a word write is on the bus.
    set_port(0, 1'b1, 1'b1, 2'b10, 32'h80, 32'hDEADBEEF);
    cyc = 0;
    while (!(mem_en === 1'b1 && mem_addr === 16'h0082) && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach_beat2", cyc < 10, 1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_mem_en", mem_en, 0);
    chk("mrst_mem_we", mem_we, 0);
    chk("mrst_ack0", r0_ack, 0);
    chk("mrst_rdata0", r0_rdata, 0);
    set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    ref_mem[16'h0080] = 8'hEF;
    ref_mem[16'h0081] = 8'hBE;
    exp_rd = '{32'h0, 32'h0};
    lg = 1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_no_ack", r0_ack, 0);
      chk("mrst_idle", busy, 0);
    end
    xfer(1, 1'b0, 2'b10, 32'h80, 32'h0, rv);
    chk("mrst_partial", rv, 32'h0000BEEF);

    // Random traffic against the byte-array model.
    for (int i = 0; i < 60; i++) begin
      a0 = rnd_addr(); a1 = rnd_addr();
      d0 = $urandom;   d1 = $urandom;
      s0 = 2'($urandom); s1 = 2'($urandom);
      w0 = 1'($urandom); w1 = 1'($urandom);
      if ($urandom_range(0, 3) == 0)
        pair(w0, s0, a0, d0, w1, s1, a1, d1);
      else
        xfer(int'($urandom_range(0, 1)), w0, s0, a0, d0, rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_req_sequencer.md
# dmem_req_sequencer

Shared data-memory controller for the MIPS design. It arbitrates between two requesters: port 0 is the CPU data port, port 1 is the loader/debug port. It executes each granted byte, halfword or word access as a sequence of single-byte accesses on a synthesizable byte-wide synchronous RAM, with little-endian lane ordering and zero-extended reads. It replaces direct combinational access to a flat byte array and sits between the datapath/loader and the physical data RAM.

## Interface
Parameters:
- ADDR_W, 16, byte-address width of the physical RAM; request addresses are truncated to ADDR_W bits.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- r0_req / r1_req  in  1  access request; hold high until the matching ack.
- r0_we / r1_we  in  1  1 = write, 0 = read.
- r0_size / r1_size  in  2  00 = byte, 01 = halfword, 10/11 = word.
- r0_addr / r1_addr  in  32  byte address of the least-significant byte.
- r0_wdata / r1_wdata  in  32  write data; byte k goes to address addr+k.
- r0_ack / r1_ack  out  1  one-cycle completion pulse.
- r0_rdata / r1_rdata  out  32  registered read result; zero-extended.
- mem_en  out  1  RAM access strobe for this cycle.
- mem_we  out  1  RAM write enable; only meaningful when mem_en = 1.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte; valid in the cycle after mem_en=1 with mem_we=0.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, BEAT, RDLAST and ACK.
- IDLE:
  - If any req is high at the clock edge, arbitrate, latch we/size/addr/wdata of the winner, set beat = 0 and go to BEAT.
  - Otherwise stay in IDLE.
- Arbitration is round-robin on a last_grant flop.
  - A single requester is always granted.
  - When both request, the port that is not last_grant wins.
  - last_grant resets to 1, so port 0 wins the first tie.
  - last_grant updates on each grant.
- Beat count N is 1 for size 00, 2 for size 01, and 4 for size 10 or 11.
- BEAT, one RAM access per cycle for beat k = 0..N-1:
  - mem_en = 1, mem_we = latched we.
  - mem_addr = (addr + k) mod 2^ADDR_W; no alignment check, so wrap-around is legal.
  - mem_wdata = wdata[8k+7:8k].
- Exit from BEAT after beat N-1:
  - A write goes to ACK.
  - A read goes to RDLAST.
- Read capture: byte k from mem_rdata is stored into lane k of an assembly register at the edge following beat k. Lanes k ≥ N are 0.
- RDLAST: mem_en = 0; capture the final byte, then go to ACK.
- ACK:
  - Pulse ack of the granted port for one cycle, then go to IDLE.
  - For reads, that port's rdata takes the assembled value on the same edge that raises ack.
  - rdata of the other port, and rdata on writes, holds its value.
- Requests on the other port during a transaction wait; their req line is ignored until IDLE. Changes on the granted port's inputs after the grant are ignored.
- A requester must deassert req at the edge ending its ack cycle; otherwise the IDLE cycle that follows accepts a new transaction.

## Timing
- All outputs are registered.
- Reset values: mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, both ack 0, both rdata 0, busy 0. State resets to IDLE and last_grant to 1.
- With acceptance at edge E:
  - Beats occupy cycles E+1 … E+N.
  - A write acks in cycle E+N+1 (latency N+1).
  - A read acks in cycle E+N+2 (latency N+2).
- Minimum gap between back-to-back transactions is one IDLE cycle.
- Reset mid-transaction:
  - Immediately returns to IDLE with mem_en/mem_we low.
  - No ack is issued.
  - RAM bytes already written stay written.
- busy rises in the cycle after acceptance and falls in the cycle after ack.

## Test plan
- Port 0 word write: addr 0x10, wdata 0xA1B2C3D4. Required response: beats at 0x10..0x13 with bytes D4, C3, B2, A1; r0_ack 5 cycles after acceptance.
- Port 0 word read of 0x10 after the write above: r0_rdata = 0xA1B2C3D4, ack at latency 6. Then a halfword read at 0x11: r0_rdata = 0x0000B2C3. Then a byte read at 0x13: r0_rdata = 0x000000A1.
- Both req high from the first cycle after reset, with port 0 a byte write and port 1 a byte write: port 0 is served first, then port 1. Repeated simultaneous requests alternate 0, 1, 0, 1.
- ADDR_W = 16, word write at 0x0000FFFE: beats at 0xFFFE, 0xFFFF, 0x0000, 0x0001. A size-11 request behaves exactly as a word request.
- Port 1 read with port 0 rdata = 0x12345678 beforehand: r0_rdata stays 0x12345678 and r0_ack stays 0 throughout.
- Assert rst during beat 2 of a word write: busy, mem_en and mem_we go to 0 immediately and no ack is issued. Bytes 0–1 are present in RAM and bytes 2–3 are unchanged. The next request is served normally.
